// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// irq_pending_ctrl : sync + edge-detect IRQ lines, hold pending, present the
// lowest enabled pending id to the core until ack. Optional NMI: IRQ_NMI_EN.
// Revision: 1.0
// ============================================================================
module irq_pending_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               nmi_in,
    output logic               int_o,
    output logic [ID_W-1:0]    int_num_o,
    output logic               nmi_o,
    output logic [NUM_IRQ-1:0] pending_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               load_id;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    sel_id;
    logic               any_enabled;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_d;
    logic [NUM_IRQ-1:0] pend_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enabled;

    // History presets to ones so a line already high at reset release is not
    // mistaken for a rising edge; a line must be seen low first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            sync_d <= '1;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pend_set = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign enabled  = pending & irq_mask;
    assign any_enabled = |enabled;

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        pend_clr = '0;
        if ((state == ASSERT) && int_ack) begin
            pend_clr = NUM_IRQ'(1) << cur_id;
        end
    end

    // Set is OR-ed after the clear so a fresh edge in the ack cycle re-pends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cur_id <= '0;
        end else begin
            state <= state_next;
            if (load_id) begin
                cur_id <= sel_id;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        case (state)
            IDLE: begin
                if (any_enabled) begin
                    state_next = ASSERT;
                    load_id    = 1'b1;
                end
            end
            ASSERT: begin
                if (int_ack) begin
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign int_o     = (state == ASSERT);
    assign int_num_o = cur_id;
    assign pending_o = pending;

`ifdef IRQ_NMI_EN
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic                   nmi_d;
    logic                   nmi_edge;
    logic                   nmi_pulse;

    // Extra edge register aligns the pulse one cycle after the pending path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nmi_sync  <= '1;
            nmi_d     <= 1'b1;
            nmi_edge  <= 1'b0;
            nmi_pulse <= 1'b0;
        end else begin
            nmi_sync  <= {nmi_sync[SYNC_STAGES-2:0], nmi_in};
            nmi_d     <= nmi_sync[SYNC_STAGES-1];
            nmi_edge  <= nmi_sync[SYNC_STAGES-1] & ~nmi_d;
            nmi_pulse <= nmi_edge;
        end
    end

    assign nmi_o = nmi_pulse;
`else
    logic unused_nmi;
    assign unused_nmi = nmi_in;
    assign nmi_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// tb_irq_pending_ctrl : directed + random stimulus against a behavioural model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_irq_pending_ctrl;
    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;
    localparam int S       = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               int_ack;
    logic               nmi_in;
    logic               int_o;
    logic [ID_W-1:0]    int_num_o;
    logic               nmi_o;
    logic [NUM_IRQ-1:0] pending_o;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .irq_mask  (irq_mask),
        .int_ack   (int_ack),
        .nmi_in    (nmi_in),
        .int_o     (int_o),
        .int_num_o (int_num_o),
        .nmi_o     (nmi_o),
        .pending_o (pending_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled-input history, pending set, delivery phase.
    logic [7:0] m_hist[$];
    logic       m_nhist[$];
    logic [7:0] m_pend;
    int         m_phase;   // 0 waiting, 1 presenting, 2 enforced low cycle
    int         m_id;
    logic       m_nmi;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_nhist.delete();
        repeat (S + 2) m_hist.push_back(8'hFF);
        repeat (S + 3) m_nhist.push_back(1'b1);
        m_pend  = '0;
        m_phase = 0;
        m_id    = 0;
        m_nmi   = 1'b0;
    endtask

    // Called at a negedge; drives, advances one posedge, checks, returns at negedge.
    task automatic step(input logic [7:0] irq, input logic [7:0] msk, input logic ack, input logic nmi);
        logic [7:0] rise;
        logic [7:0] clr;
        logic [7:0] en;
        int t;
        irq_in   = irq;
        irq_mask = msk;
        int_ack  = ack;
        nmi_in   = nmi;
        @(posedge clk);
        m_hist.push_back(irq);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        t    = m_hist.size() - 1;
        rise = m_hist[t-S] & ~m_hist[t-S-1];
        m_nhist.push_back(nmi);
        if (m_nhist.size() > 8) void'(m_nhist.pop_front());
        t     = m_nhist.size() - 1;
        m_nmi = m_nhist[t-S-1] & ~m_nhist[t-S-2];
        en    = m_pend & msk;
        clr   = (m_phase == 1 && ack) ? (8'h01 << m_id) : 8'h00;
        case (m_phase)
            0: if (en != 0) begin m_phase = 1; m_id = lowest(en); end
            1: if (ack) m_phase = 2;
            default: m_phase = 0;
        endcase
        m_pend = (m_pend & ~clr) | rise;
        #1;
        check("int_o", {31'd0, int_o}, (m_phase == 1) ? 32'd1 : 32'd0);
        if (m_phase == 1) check("int_num", {29'd0, int_num_o}, m_id);
        check("pending", {24'd0, pending_o}, {24'd0, m_pend});
`ifdef IRQ_NMI_EN
        check("nmi", {31'd0, nmi_o}, {31'd0, m_nmi});
`else
        check("nmi", {31'd0, nmi_o}, 32'd0);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] irq);
        rst      = 1'b0;
        irq_in   = irq;
        int_ack  = 1'b0;
        #1;
        check("rst_int_o", {31'd0, int_o}, 32'd0);
        check("rst_int_num", {29'd0, int_num_o}, 32'd0);
        check("rst_pending", {24'd0, pending_o}, 32'd0);
        check("rst_nmi", {31'd0, nmi_o}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_int_o", {31'd0, int_o}, 32'd0);
        rst = 1'b1;
        model_reset();
    endtask

    logic [7:0] cur_irq;
    logic [7:0] cur_mask;
    logic       cur_nmi;

    initial begin
        rst = 1'b0; irq_in = 8'hFF; irq_mask = 8'hFF; int_ack = 1'b0; nmi_in = 1'b0;
        @(negedge clk);
        do_reset(8'hFF);
        repeat (4) step(8'hFF, 8'hFF, 1'b0, 1'b0);
        check("t1_no_pend", {24'd0, pending_o}, 32'd0);

        // single line
        repeat (3) step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h20, 8'hFF, 1'b0, 1'b0);
        step(8'h20, 8'hFF, 1'b0, 1'b0);
        step(8'h20, 8'hFF, 1'b0, 1'b0);
        check("t2_pend", {24'd0, pending_o}, 32'h20);
        step(8'h20, 8'hFF, 1'b0, 1'b0);
        check("t2_int", {31'd0, int_o}, 32'd1);
        check("t2_num", {29'd0, int_num_o}, 32'd5);
        step(8'h20, 8'hFF, 1'b1, 1'b0);
        check("t2_ack_int", {31'd0, int_o}, 32'd0);
        check("t2_ack_pend", {24'd0, pending_o}, 32'd0);
        repeat (2) step(8'h00, 8'hFF, 1'b0, 1'b0);

        // priority
        step(8'h44, 8'hFF, 1'b0, 1'b0);
        repeat (3) step(8'h44, 8'hFF, 1'b0, 1'b0);
        check("t3_first", {29'd0, int_num_o}, 32'd2);
        step(8'h44, 8'hFF, 1'b1, 1'b0);
        step(8'h44, 8'hFF, 1'b0, 1'b0);
        step(8'h44, 8'hFF, 1'b0, 1'b0);
        check("t3_second_int", {31'd0, int_o}, 32'd1);
        check("t3_second", {29'd0, int_num_o}, 32'd6);
        step(8'h44, 8'hFF, 1'b1, 1'b0);
        repeat (2) step(8'h00, 8'hFF, 1'b0, 1'b0);

        // mask holds delivery, not latching
        step(8'h02, 8'h00, 1'b0, 1'b0);
        repeat (3) step(8'h02, 8'h00, 1'b0, 1'b0);
        check("t4_pend", {24'd0, pending_o}, 32'h02);
        check("t4_masked", {31'd0, int_o}, 32'd0);
        step(8'h02, 8'h02, 1'b0, 1'b0);
        check("t4_unmask_int", {31'd0, int_o}, 32'd1);
        check("t4_unmask_num", {29'd0, int_num_o}, 32'd1);
        step(8'h02, 8'h00, 1'b0, 1'b0);
        check("t4_mask_hold", {31'd0, int_o}, 32'd1);
        step(8'h02, 8'h00, 1'b1, 1'b0);
        repeat (2) step(8'h00, 8'hFF, 1'b0, 1'b0);

        // ack collides with a new edge on the same line
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        repeat (3) step(8'h08, 8'hFF, 1'b0, 1'b0);
        check("t5_num", {29'd0, int_num_o}, 32'd3);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h00, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b1, 1'b0);
        check("t5_repend", {31'd0, pending_o[3]}, 32'd1);
        check("t5_low", {31'd0, int_o}, 32'd0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        step(8'h08, 8'hFF, 1'b0, 1'b0);
        check("t5_again_int", {31'd0, int_o}, 32'd1);
        check("t5_again_num", {29'd0, int_num_o}, 32'd3);

        // NMI while presenting; also an ignored ack outside presenting below
        step(8'h08, 8'hFF, 1'b0, 1'b1);
        step(8'h08, 8'hFF, 1'b0, 1'b1);
        step(8'h08, 8'hFF, 1'b0, 1'b1);
        step(8'h08, 8'hFF, 1'b0, 1'b1);
`ifdef IRQ_NMI_EN
        check("t6_nmi", {31'd0, nmi_o}, 32'd1);
`else
        check("t6_nmi", {31'd0, nmi_o}, 32'd0);
`endif
        check("t6_int_kept", {31'd0, int_o}, 32'd1);
        step(8'h08, 8'hFF, 1'b0, 1'b1);
        check("t6_nmi_end", {31'd0, nmi_o}, 32'd0);
        step(8'h08, 8'hFF, 1'b1, 1'b0);
        step(8'h08, 8'hFF, 1'b1, 1'b0);
        check("t6_ack_ignored", {24'd0, pending_o}, 32'd0);

        // random traffic with one reset in the middle
        cur_irq = 8'h00; cur_mask = 8'hFF; cur_nmi = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic ack;
            if (c == 700) begin
                do_reset(cur_irq);
            end
            for (int b = 0; b < NUM_IRQ; b++) begin
                if ($urandom_range(0, 7) == 0) cur_irq[b] = ~cur_irq[b];
            end
            if ($urandom_range(0, 9) == 0) cur_nmi = ~cur_nmi;
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0: cur_mask = 8'hFF;
                    1: cur_mask = 8'h00;
                    default: cur_mask = 8'($urandom);
                endcase
            end
            ack = int_o ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(cur_irq, cur_mask, ack, cur_nmi);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
